// File: rtl/gpu_sched_pkg.sv
// Shared definitions for the frame scheduler and the core dispatch controller.
// Holds the core/instruction geometry, fence encodings and the dispatch FSM states.
package gpu_sched_pkg;

   localparam int unsigned N_CORES = 16;
   localparam int unsigned IF_W    = 6;
   localparam int unsigned INSTR_W = 32;

   localparam logic [1:0] FENCE_NONE   = 2'd0;
   localparam logic [1:0] FENCE_FRAME  = 2'd1;
   localparam logic [1:0] FENCE_GLOBAL = 2'd2;

   // Frame header layout as seen by the scheduler: word0 = {fence, if_num}, word1 = mask,
   // word2 = r0.
   localparam int unsigned HDR_FENCE_MSB = 7;
   localparam int unsigned HDR_FENCE_LSB = 6;
   localparam int unsigned HDR_IFNUM_MSB = 5;
   localparam int unsigned HDR_IFNUM_LSB = 0;
   localparam int unsigned HDR_MASK_WORD = 1;
   localparam int unsigned HDR_R0_WORD   = 2;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StIssue,
      StFence
   } disp_state_e;

   // Encoding 3 behaves as a global barrier.
   function automatic logic fence_is_global(input logic [1:0] fence);
      return fence[1];
   endfunction

endpackage

// File: rtl/bcast_hold.sv
// Broadcast hold register: one instruction word plus the mask of cores that still owe an ack.
// A word completes when its last ack arrives, or on load if nobody is targeted.
module bcast_hold
   import gpu_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [INSTR_W-1:0] data_i,
   input  logic [N_CORES-1:0] mask_i,
   input  logic [N_CORES-1:0] ack_i,
   output logic [N_CORES-1:0] pend_o,
   output logic [INSTR_W-1:0] data_o,
   output logic               ready_o,
   output logic               complete_o
);

   logic [N_CORES-1:0] pend_q, pend_d, pend_left;
   logic [INSTR_W-1:0] hold_q, hold_d;

   always_comb begin
      pend_left  = pend_q & ~ack_i;
      ready_o    = (pend_left == '0);
      complete_o = ((pend_q != '0) && ready_o) || (load_i && (mask_i == '0));
      pend_d     = pend_left;
      hold_d     = hold_q;
      if (load_i) begin
         pend_d = mask_i;
         hold_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
         hold_q <= '0;
      end else begin
         pend_q <= pend_d;
         hold_q <= hold_d;
      end
   end

   assign pend_o = pend_q;
   assign data_o = hold_q;

endmodule

// File: rtl/core_dispatch_ctrl.sv
// Dispatches one frame at a time to the shader cores: start pulse, broadcast of the
// instruction words with per-core acks, busy tracking and the post-frame barrier.
module core_dispatch_ctrl
   import gpu_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frm_valid_i,
   output logic               frm_ready_o,
   input  logic [N_CORES-1:0] frm_mask_i,
   input  logic [1:0]         frm_fence_i,
   input  logic [IF_W-1:0]    frm_if_num_i,
   input  logic [N_CORES-1:0] frm_r0_i,
   input  logic               instr_valid_i,
   output logic               instr_ready_o,
   input  logic [INSTR_W-1:0] instr_data_i,
   output logic [N_CORES-1:0] core_start_o,
   output logic [N_CORES-1:0] core_r0_o,
   output logic [N_CORES-1:0] core_instr_valid_o,
   output logic [INSTR_W-1:0] core_instr_data_o,
   input  logic [N_CORES-1:0] core_instr_ack_i,
   input  logic [N_CORES-1:0] core_done_i,
   output logic [N_CORES-1:0] busy_mask_o,
   output logic               idle_o,
   output logic               err_empty_mask_o
);

   disp_state_e        state_q, state_d, post_state;
   logic [N_CORES-1:0] busy_q, busy_d;
   logic [N_CORES-1:0] mask_q, mask_d;
   logic [N_CORES-1:0] r0_q, r0_d;
   logic [1:0]         fence_q, fence_d;
   logic [IF_W-1:0]    remaining_q, remaining_d;
   logic [IF_W-1:0]    to_send;
   logic [N_CORES-1:0] pend;
   logic               accept, xfer, hold_ready, word_done, fence_met, in_flight;

   assign xfer      = instr_valid_i && instr_ready_o;
   assign in_flight = (pend != '0);

   bcast_hold u_bcast_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (xfer),
      .data_i     (instr_data_i),
      .mask_i     (mask_q),
      .ack_i      (core_instr_ack_i),
      .pend_o     (pend),
      .data_o     (core_instr_data_o),
      .ready_o    (hold_ready),
      .complete_o (word_done)
   );

   always_comb begin
      // remaining still counts the word in the hold register until it completes
      to_send = remaining_q - {{(IF_W-1){1'b0}}, in_flight};

      if (fence_q == FENCE_NONE) begin
         fence_met = 1'b1;
      end else if (fence_is_global(fence_q)) begin
         fence_met = (busy_q == '0);
      end else begin
         fence_met = ((busy_q & mask_q) == '0);
      end
      post_state = (fence_q == FENCE_NONE) ? StIdle : StFence;
   end

   always_comb begin
      state_d          = state_q;
      mask_d           = mask_q;
      r0_d             = r0_q;
      fence_d          = fence_q;
      remaining_d      = remaining_q;
      accept           = 1'b0;
      instr_ready_o    = 1'b0;
      core_start_o     = '0;
      core_r0_o        = '0;
      err_empty_mask_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            accept = frm_valid_i && ((frm_mask_i & busy_q) == '0);
            if (accept) begin
               mask_d           = frm_mask_i;
               r0_d             = frm_r0_i;
               fence_d          = frm_fence_i;
               remaining_d      = frm_if_num_i;
               err_empty_mask_o = (frm_mask_i == '0);
               state_d          = StStart;
            end
         end
         StStart: begin
            core_start_o = mask_q;
            core_r0_o    = r0_q & mask_q;
            state_d      = (remaining_q == '0) ? post_state : StIssue;
         end
         StIssue: begin
            instr_ready_o = hold_ready && (to_send != '0);
            if (word_done) begin
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == {{(IF_W-1){1'b0}}, 1'b1}) begin
                  state_d = post_state;
               end
            end
         end
         StFence: begin
            if (fence_met) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (busy_q & ~core_done_i) | (accept ? frm_mask_i : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         busy_q      <= '0;
         mask_q      <= '0;
         r0_q        <= '0;
         fence_q     <= FENCE_NONE;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         mask_q      <= mask_d;
         r0_q        <= r0_d;
         fence_q     <= fence_d;
         remaining_q <= remaining_d;
      end
   end

   assign frm_ready_o        = accept;
   assign core_instr_valid_o = pend;
   assign busy_mask_o        = busy_q;
   assign idle_o             = (state_q == StIdle) && (busy_q == '0);

endmodule

// File: tb/tb_core_dispatch_ctrl.sv
// Bench for core_dispatch_ctrl: directed vector table, barrier/reset sequences, then random
// frames checked against a frame-level scoreboard of busy cores and delivered words.
module tb_core_dispatch_ctrl;
   import gpu_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frm_valid, frm_ready;
   logic [15:0] frm_mask, frm_r0;
   logic [1:0]  frm_fence;
   logic [5:0]  frm_if_num;
   logic        instr_valid, instr_ready;
   logic [31:0] instr_data, core_instr_data;
   logic [15:0] core_start, core_r0, core_instr_valid, core_instr_ack, core_done, busy_mask;
   logic        idle, err_empty;

   core_dispatch_ctrl dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .frm_valid_i        (frm_valid),
      .frm_ready_o        (frm_ready),
      .frm_mask_i         (frm_mask),
      .frm_fence_i        (frm_fence),
      .frm_if_num_i       (frm_if_num),
      .frm_r0_i           (frm_r0),
      .instr_valid_i      (instr_valid),
      .instr_ready_o      (instr_ready),
      .instr_data_i       (instr_data),
      .core_start_o       (core_start),
      .core_r0_o          (core_r0),
      .core_instr_valid_o (core_instr_valid),
      .core_instr_data_o  (core_instr_data),
      .core_instr_ack_i   (core_instr_ack),
      .core_done_i        (core_done),
      .busy_mask_o        (busy_mask),
      .idle_o             (idle),
      .err_empty_mask_o   (err_empty)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fv;
      logic [15:0] fmask;
      logic [1:0]  ffence;
      logic [5:0]  fifn;
      logic [15:0] fr0;
      logic        iv;
      logic [31:0] idata;
      logic [15:0] ack;
      logic [15:0] done;
      logic        e_fready;
      logic [15:0] e_start;
      logic [15:0] e_r0;
      logic [15:0] e_civ;
      logic [31:0] e_data;
      logic        e_iready;
      logic [15:0] e_busy;
      logic        e_idle;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic fv, input logic [15:0] fmask, input logic [1:0] ffence, input logic [5:0] fifn,
      input logic [15:0] fr0, input logic iv, input logic [31:0] idata, input logic [15:0] ack,
      input logic [15:0] done, input logic e_fready, input logic [15:0] e_start,
      input logic [15:0] e_r0, input logic [15:0] e_civ, input logic [31:0] e_data,
      input logic e_iready, input logic [15:0] e_busy, input logic e_idle, input logic e_err);
      vec_t v;
      v.fv = fv; v.fmask = fmask; v.ffence = ffence; v.fifn = fifn; v.fr0 = fr0;
      v.iv = iv; v.idata = idata; v.ack = ack; v.done = done;
      v.e_fready = e_fready; v.e_start = e_start; v.e_r0 = e_r0; v.e_civ = e_civ;
      v.e_data = e_data; v.e_iready = e_iready; v.e_busy = e_busy; v.e_idle = e_idle;
      v.e_err = e_err;
      return v;
   endfunction

   task automatic drive_quiet();
      frm_valid = 0; frm_mask = 0; frm_fence = 0; frm_if_num = 0; frm_r0 = 0;
      instr_valid = 0; instr_data = 0; core_instr_ack = 0; core_done = 0;
   endtask

   task automatic send_frame(input logic [15:0] m, input logic [1:0] f, input logic [5:0] n);
      @(posedge clk); #1;
      frm_valid = 1; frm_mask = m; frm_fence = f; frm_if_num = n; frm_r0 = 16'hFFFF;
      @(negedge clk);
      chk($sformatf("send_%h.frm_ready", m), 32'(frm_ready), 1);
      @(posedge clk); #1;
      frm_valid = 0;
   endtask

   // Frame 00F0 with a barrier; cores 4..7 finish on cycles 3,5,7,9 and core 0 on d0.
   task automatic fence_seq(input logic [1:0] fen, input int d0);
      int exp_k;
      exp_k = ((d0 > 9) ? d0 : 9) + 2;
      @(posedge clk); #1;
      frm_valid = 1; frm_mask = 16'h00F0; frm_fence = fen; frm_if_num = 0; frm_r0 = 0;
      core_done = 0;
      @(negedge clk);
      chk($sformatf("fence%0d.accept", fen), 32'(frm_ready), 1);
      for (int k = 1; k <= exp_k; k++) begin
         @(posedge clk); #1;
         frm_mask = 16'h0002; frm_fence = 0; frm_valid = 1;
         core_done = 0;
         if (k == 3) core_done[4] = 1;
         if (k == 5) core_done[5] = 1;
         if (k == 7) core_done[6] = 1;
         if (k == 9) core_done[7] = 1;
         if (d0 != 0 && k == d0) core_done[0] = 1;
         @(negedge clk);
         chk($sformatf("fence%0d.k%0d.frm_ready", fen, k), 32'(frm_ready), 32'(k == exp_k));
      end
      @(posedge clk); #1;
      frm_valid = 0; core_done = 0;
   endtask

   // scoreboard state for the random phase
   logic [15:0] m_busy, cur_mask, st_mask, st_r0;
   logic [1:0]  cur_fence;
   int          cur_ifn, words_sent, frames_left, cyc;
   logic [31:0] wlog[$];
   int          rx_cnt[16];
   bit          have_desc, first_frame, start_exp, drained, acc, xf;

   task automatic frame_end_checks();
      chk("rnd.words_sent", 32'(words_sent), 32'(cur_ifn));
      for (int i = 0; i < 16; i++) begin
         if (cur_mask[i]) chk($sformatf("rnd.core%0d.rx_count", i), 32'(rx_cnt[i]), 32'(cur_ifn));
      end
   endtask

   initial begin
      drive_quiet();
      rst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.idle", 32'(idle), 1);
      chk("reset.busy_mask", 32'(busy_mask), 0);
      chk("reset.core_instr_valid", 32'(core_instr_valid), 0);
      chk("reset.core_start", 32'(core_start), 0);
      chk("reset.instr_ready", 32'(instr_ready), 0);
      chk("reset.err_empty_mask", 32'(err_empty), 0);
      rst_n = 1;

      // fv mask fen ifn r0 | iv data ack done || frdy start r0 civ data irdy busy idle err
      vecs.push_back(mk(1, 16'h000F, 0, 2, 16'h0005, 0, 0, 0, 0,
                        1, 0, 0, 0, 0, 0, 16'h0000, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA000_0001, 0, 0,
                        0, 16'h000F, 16'h0005, 0, 0, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA000_0001, 0, 0,
                        0, 0, 0, 0, 0, 1, 16'h000F, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hA000_0002, 16'h000F, 0,
                        0, 0, 0, 16'h000F, 32'hA000_0001, 1, 16'h000F, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h000F, 0,
                        0, 0, 0, 16'h000F, 32'hA000_0002, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h000F,
                        0, 0, 0, 0, 0, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(1, 16'h0003, 0, 2, 0, 0, 0, 0, 0,
                        1, 0, 0, 0, 0, 0, 16'h0000, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0001, 0, 0,
                        0, 16'h0003, 0, 0, 0, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0001, 0, 0,
                        0, 0, 0, 0, 0, 1, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0002, 0, 0,
                        0, 0, 0, 16'h0003, 32'hB000_0001, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0002, 16'h0001, 0,
                        0, 0, 0, 16'h0003, 32'hB000_0001, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0002, 0, 0,
                        0, 0, 0, 16'h0002, 32'hB000_0001, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0002, 0, 0,
                        0, 0, 0, 16'h0002, 32'hB000_0001, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB000_0002, 16'h0002, 0,
                        0, 0, 0, 16'h0002, 32'hB000_0001, 1, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0003, 0,
                        0, 0, 0, 16'h0003, 32'hB000_0002, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(1, 16'h0000, 0, 3, 16'hFFFF, 0, 0, 0, 0,
                        1, 0, 0, 0, 0, 0, 16'h0003, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC000_0001, 0, 0,
                        0, 0, 0, 0, 0, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC000_0001, 0, 0,
                        0, 0, 0, 0, 0, 1, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC000_0002, 0, 0,
                        0, 0, 0, 0, 0, 1, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC000_0003, 0, 0,
                        0, 0, 0, 0, 0, 1, 16'h0003, 0, 0));
      vecs.push_back(mk(1, 16'h000C, 0, 0, 16'hFFFF, 1, 32'hC000_0004, 0, 0,
                        1, 0, 0, 0, 0, 0, 16'h0003, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 16'h000C, 16'h000C, 0, 0, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(1, 16'h0018, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(1, 16'h0018, 0, 0, 0, 0, 0, 0, 16'h0008,
                        0, 0, 0, 0, 0, 0, 16'h000F, 0, 0));
      vecs.push_back(mk(1, 16'h0018, 0, 0, 0, 0, 0, 0, 0,
                        1, 0, 0, 0, 0, 0, 16'h0007, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h001F,
                        0, 16'h0018, 0, 0, 0, 0, 16'h001F, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,
                        0, 0, 0, 0, 0, 0, 16'h0000, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         frm_valid = vecs[i].fv; frm_mask = vecs[i].fmask; frm_fence = vecs[i].ffence;
         frm_if_num = vecs[i].fifn; frm_r0 = vecs[i].fr0;
         instr_valid = vecs[i].iv; instr_data = vecs[i].idata;
         core_instr_ack = vecs[i].ack; core_done = vecs[i].done;
         @(negedge clk);
         chk($sformatf("v%0d.frm_ready", i), 32'(frm_ready), 32'(vecs[i].e_fready));
         chk($sformatf("v%0d.core_start", i), 32'(core_start), 32'(vecs[i].e_start));
         chk($sformatf("v%0d.core_r0", i), 32'(core_r0), 32'(vecs[i].e_r0));
         chk($sformatf("v%0d.core_instr_valid", i), 32'(core_instr_valid), 32'(vecs[i].e_civ));
         if (vecs[i].e_civ != 0)
            chk($sformatf("v%0d.core_instr_data", i), core_instr_data, vecs[i].e_data);
         chk($sformatf("v%0d.instr_ready", i), 32'(instr_ready), 32'(vecs[i].e_iready));
         chk($sformatf("v%0d.busy_mask", i), 32'(busy_mask), 32'(vecs[i].e_busy));
         chk($sformatf("v%0d.idle", i), 32'(idle), 32'(vecs[i].e_idle));
         chk($sformatf("v%0d.err_empty_mask", i), 32'(err_empty), 32'(vecs[i].e_err));
      end
      @(posedge clk); #1;
      drive_quiet();

      // barriers, with core 0 busy from an unrelated frame
      send_frame(16'h0001, 0, 0);
      fence_seq(1, 0);
      repeat (2) @(posedge clk);
      #1 core_done = 16'h0002;
      @(posedge clk); #1 core_done = 0;
      @(negedge clk);
      chk("fence.busy_before_global", 32'(busy_mask), 32'h0001);
      fence_seq(2, 12);
      repeat (2) @(posedge clk);
      #1 core_done = 16'h0002;
      @(posedge clk); #1 core_done = 0;
      @(negedge clk);
      chk("fence.idle_after_global", 32'(idle), 1);

      // asynchronous reset while a word is pending on eight cores
      send_frame(16'h00FF, 0, 2);
      instr_valid = 1; instr_data = 32'hDEAD_BEEF;
      @(posedge clk);
      @(posedge clk); #1;
      instr_valid = 0;
      @(negedge clk);
      chk("rstmid.pend_before", 32'(core_instr_valid), 32'h00FF);
      chk("rstmid.data_before", core_instr_data, 32'hDEAD_BEEF);
      #2 rst_n = 0;
      #1;
      chk("rstmid.core_instr_valid", 32'(core_instr_valid), 0);
      chk("rstmid.busy_mask", 32'(busy_mask), 0);
      chk("rstmid.idle", 32'(idle), 1);
      @(negedge clk);
      rst_n = 1;

      // random frames against the scoreboard
      m_busy = 0; cur_mask = 0; cur_fence = 0; cur_ifn = 0; words_sent = 0;
      st_mask = 0; st_r0 = 0; start_exp = 0; have_desc = 0; first_frame = 1; drained = 0;
      frames_left = 80; cyc = 0;
      foreach (rx_cnt[i]) rx_cnt[i] = 0;
      while (!drained) begin
         @(posedge clk); #1;
         if (!have_desc && frames_left > 0 && $urandom_range(0, 3) != 0) begin
            frm_mask = ($urandom_range(0, 7) == 0) ? 16'h0 :
                       (16'($urandom) & 16'($urandom) & 16'($urandom));
            frm_fence = 2'($urandom_range(0, 3));
            frm_if_num = 6'($urandom_range(0, 5));
            frm_r0 = 16'($urandom);
            have_desc = 1;
         end
         frm_valid = have_desc;
         instr_valid = ($urandom_range(0, 9) < 7);
         instr_data = $urandom;
         core_instr_ack = (core_instr_valid & 16'($urandom)) |
                          (16'($urandom) & 16'($urandom) & 16'($urandom));
         core_done = 0;
         for (int i = 0; i < 16; i++) begin
            if (m_busy[i] && $urandom_range(0, 5) == 0) core_done[i] = 1;
         end
         if ($urandom_range(0, 19) == 0) core_done[$urandom_range(0, 15)] = 1;

         @(negedge clk);
         acc = frm_valid && frm_ready;
         xf = instr_valid && instr_ready;
         chk("rnd.busy_mask", 32'(busy_mask), 32'(m_busy));
         chk("rnd.core_start", 32'(core_start), start_exp ? 32'(st_mask) : 0);
         chk("rnd.core_r0", 32'(core_r0), start_exp ? 32'(st_r0 & st_mask) : 0);
         chk("rnd.err_empty_mask", 32'(err_empty), 32'(acc && frm_mask == 0));
         chk("rnd.valid_outside_mask", 32'(core_instr_valid & ~cur_mask), 0);
         if (idle) chk("rnd.idle_busy", 32'(busy_mask), 0);
         for (int i = 0; i < 16; i++) begin
            if (core_instr_valid[i] && core_instr_ack[i]) begin
               if (rx_cnt[i] < wlog.size())
                  chk($sformatf("rnd.core%0d.word%0d", i, rx_cnt[i]), core_instr_data,
                      wlog[rx_cnt[i]]);
               else
                  chk($sformatf("rnd.core%0d.extra_word", i), 32'(rx_cnt[i]), 32'(wlog.size()));
               rx_cnt[i]++;
            end
         end
         if (xf) begin
            chk("rnd.word_within_count", 32'(words_sent < cur_ifn), 1);
            wlog.push_back(instr_data);
            words_sent++;
         end
         if (acc) begin
            chk("rnd.accept_overlap", 32'(frm_mask & m_busy), 0);
            if (!first_frame) begin
               frame_end_checks();
               if (cur_fence == 2'd1) chk("rnd.frame_fence", 32'(m_busy & cur_mask), 0);
               if (cur_fence >= 2'd2) chk("rnd.global_fence", 32'(m_busy), 0);
            end
            cur_mask = frm_mask; cur_fence = frm_fence; cur_ifn = int'(frm_if_num);
            words_sent = 0; wlog.delete();
            foreach (rx_cnt[i]) rx_cnt[i] = 0;
            first_frame = 0; have_desc = 0; frames_left--;
         end
         start_exp = acc; st_mask = frm_mask; st_r0 = frm_r0;
         m_busy = (m_busy & ~core_done) | (acc ? frm_mask : 16'h0);
         cyc++;
         if (frames_left == 0 && !have_desc && !acc && idle) begin
            frame_end_checks();
            drained = 1;
         end else if (cyc > 20000) begin
            checks++;
            errors++;
            $display("FAIL rnd.timeout: got %0d cycles, required drain within 20000", cyc);
            drained = 1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
